// File: rtl/truth_table_bist_ctrl.sv
// BIST sequencer for a small combinational truth-table datapath: sweeps every
// input vector, waits a settle time, samples r and accumulates miscompares.
module truth_table_bist_ctrl #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   ref_table,
    output logic [N_IN-1:0]      tt_in,
    input  logic                 tt_r,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   mismatch_mask,
    output logic [N_IN:0]        err_cnt,
    output logic                 pass
);

    localparam int N_VEC = 2**N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             state;
    logic [N_VEC-1:0]   ref_q;
    logic [CNT_W-1:0]   cnt;
    logic               miscompare;

    // tt_in doubles as the vector index; an unknown r never matches the reference.
    assign miscompare = (tt_r !== ref_q[tt_in]);
    assign pass       = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tt_in         <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mismatch_mask <= '0;
            err_cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ref_q         <= ref_table;
                        mismatch_mask <= '0;
                        err_cnt       <= '0;
                        tt_in         <= '0;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        state         <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_W'(SETTLE - 1)) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (miscompare) begin
                        mismatch_mask[tt_in] <= 1'b1;
                        err_cnt              <= err_cnt + 1'b1;
                    end
                    if (&tt_in) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        tt_in <= tt_in + 1'b1;
                        cnt   <= '0;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_bist_ctrl.sv
// Directed bench for truth_table_bist_ctrl: table-driven full sweeps on a
// SETTLE=1 instance plus hand-written restart/reset/settle sequences.
module tb_truth_table_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    int         n_tests = 0;
    int         n_fail  = 0;

    // SETTLE = 1 instance
    logic       start;
    logic [7:0] ref_table;
    logic [2:0] tt_in;
    logic       tt_r;
    logic       busy, done, pass;
    logic [7:0] mismatch_mask;
    logic [3:0] err_cnt;
    logic [1:0] mode;

    // SETTLE = 3 instance
    logic       start3;
    logic [7:0] ref_table3;
    logic [2:0] tt_in3;
    logic       tt_r3;
    logic       busy3, done3, pass3;
    logic [7:0] mismatch_mask3;
    logic [3:0] err_cnt3;

    always #5 clk = ~clk;

    truth_table_bist_ctrl #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_table(ref_table),
        .tt_in(tt_in), .tt_r(tt_r), .busy(busy), .done(done),
        .mismatch_mask(mismatch_mask), .err_cnt(err_cnt), .pass(pass)
    );

    truth_table_bist_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .ref_table(ref_table3),
        .tt_in(tt_in3), .tt_r(tt_r3), .busy(busy3), .done(done3),
        .mismatch_mask(mismatch_mask3), .err_cnt(err_cnt3), .pass(pass3)
    );

    function automatic logic golden(input logic [2:0] v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return (~a & ~b & c) | (~a & b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    endfunction

    // mode 0: golden, 1: inverted, 2: X at vector 5
    always_comb begin
        tt_r = golden(tt_in);
        case (mode)
            2'd1: tt_r = ~golden(tt_in);
            2'd2: tt_r = (tt_in == 3'd5) ? 1'bx : golden(tt_in);
            default: tt_r = golden(tt_in);
        endcase
    end

    assign tt_r3 = golden(tt_in3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] ref_tab;
        logic [1:0] mode;
        logic [7:0] exp_mask;
        logic [3:0] exp_err;
        logic       exp_pass;
        logic       repulse;
    } vec_t;

    vec_t vecs[7];

    // Full sweep on the SETTLE=1 instance; ref_table is scrambled after the
    // accepting edge, and optionally start is re-pulsed mid-sweep.
    task automatic run_sweep(input vec_t v);
        mode      = v.mode;
        ref_table = v.ref_tab;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        ref_table = ~v.ref_tab;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done", 32'(done), 32'd0);
        check("accept_mask", 32'(mismatch_mask), 32'h0);
        check("accept_err",  32'(err_cnt), 32'd0);
        for (int k = 0; k < 16; k++) begin
            check("tt_in_step", 32'(tt_in), 32'(k / 2));
            if (k == 15) check("done_early", 32'(done), 32'd0);
            if (v.repulse && k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
            tick();
        end
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_mask", 32'(mismatch_mask), 32'(v.exp_mask));
        check("end_err",  32'(err_cnt), 32'(v.exp_err));
        check("end_pass", 32'(pass), 32'(v.exp_pass));
    endtask

    initial begin
        vecs[0] = '{8'h36, 2'd0, 8'h00, 4'd0, 1'b1, 1'b0};
        vecs[1] = '{8'h3E, 2'd0, 8'h08, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{8'h36, 2'd1, 8'hFF, 4'd8, 1'b0, 1'b0};
        vecs[3] = '{8'h36, 2'd2, 8'h20, 4'd1, 1'b0, 1'b0};
        vecs[4] = '{8'h36, 2'd0, 8'h00, 4'd0, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 2'd0, 8'h36, 4'd4, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 2'd0, 8'hC9, 4'd4, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        ref_table = 8'h00; ref_table3 = 8'h00; mode = 2'd0;
        tick();
        tick();
        check("rst_tt_in", 32'(tt_in), 32'h0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_mask",  32'(mismatch_mask), 32'h0);
        check("rst_err",   32'(err_cnt), 32'd0);
        check("rst_pass",  32'(pass), 32'd0);

        // rst wins over a coincident start
        start = 1'b1; ref_table = 8'h36;
        tick();
        check("rst_over_start_busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle_hold_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

        // results hold in DONE without start
        tick();
        tick();
        check("done_hold_done", 32'(done), 32'd1);
        check("done_hold_mask", 32'(mismatch_mask), 32'hC9);
        check("done_hold_err",  32'(err_cnt), 32'd4);

        // reset mid-sweep discards the partial sweep
        mode = 2'd1; ref_table = 8'h36; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_tt_in", 32'(tt_in), 32'h0);
        check("mid_rst_mask",  32'(mismatch_mask), 32'h0);
        check("mid_rst_err",   32'(err_cnt), 32'd0);
        tick();
        tick();
        check("mid_rst_idle", 32'(busy), 32'd0);
        run_sweep(vecs[0]);

        // SETTLE = 3: each vector held four cycles, done after 32 edges
        ref_table3 = 8'h36; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("s3_tt_in", 32'(tt_in3), 32'(k / 4));
            if (k == 31) check("s3_done_early", 32'(done3), 32'd0);
            tick();
        end
        check("s3_done", 32'(done3), 32'd1);
        check("s3_pass", 32'(pass3), 32'd1);

        // SETTLE = 3 with a faulty reference, then restart straight from DONE
        ref_table3 = 8'h3E; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        check("s3_bad_mask", 32'(mismatch_mask3), 32'h08);
        check("s3_bad_pass", 32'(pass3), 32'd0);
        ref_table3 = 8'h36; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("s3_restart_done", 32'(done3), 32'd0);
        check("s3_restart_mask", 32'(mismatch_mask3), 32'h0);
        check("s3_restart_busy", 32'(busy3), 32'd1);
        for (int k = 0; k < 32; k++) tick();
        check("s3_restart_end_done", 32'(done3), 32'd1);
        check("s3_restart_end_err",  32'(err_cnt3), 32'd0);
        check("s3_restart_end_pass", 32'(pass3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_bist_ctrl.md
Name: truth_table_bist_ctrl

Overview:
Built-in self-test sequencer for a small combinational truth-table datapath (inputs a,b,c; output r). On start it latches a reference table and sweeps every input combination in ascending order. For each combination it drives the datapath inputs, waits a programmable settle time and samples r. It reports a per-vector mismatch mask, an error count and a pass flag to the bench or system controller.

Parameters:
N_IN, 3, number of datapath inputs; 2**N_IN vectors per sweep
SETTLE, 1, cycles tt_in is held before sampling; legal range >= 1

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; accepted only in IDLE or DONE
ref_table  input  2**N_IN  expected r per vector; bit i = expected r for tt_in == i; latched on accepted start
tt_in  output  N_IN  datapath input vector; tt_in[N_IN-1] = a (MSB) ... tt_in[0] = c
tt_r  input  1  datapath result r
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until the next accepted start or rst
mismatch_mask  output  2**N_IN  bit i set if vector i miscompared
err_cnt  output  N_IN+1  number of miscompared vectors; 0..2**N_IN
pass  output  1  done && err_cnt == 0

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE. Registered outputs clear: tt_in=0, busy=0, done=0, mismatch_mask=0, err_cnt=0. pass is therefore 0. rst overrides start in the same cycle.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start=1:
  - latch ref_table
  - clear mismatch_mask and err_cnt
  - idx=0, tt_in=0, settle counter=0
  - go to DRIVE; busy=1, done=0 next cycle
- IDLE/DONE + start=0: remain; previous results hold in DONE.
- DRIVE: tt_in=idx held stable; counter increments each cycle. After SETTLE cycles in DRIVE, go to SAMPLE.
- SAMPLE: lasts exactly 1 cycle; tt_in unchanged.
  - At the closing edge, mismatch = (tt_r !== latched_ref[idx]); tt_r of X/Z counts as a mismatch.
  - On mismatch, set mismatch_mask[idx] and increment err_cnt.
  - If idx == 2**N_IN-1: go to DONE, busy=0, done=1.
  - Otherwise: idx+1, tt_in=idx+1, counter=0, back to DRIVE.
- Timing: start accepted at edge T gives busy=1 from T+1. Each vector takes SETTLE+1 cycles. done=1 at T+(2**N_IN)*(SETTLE+1)+1; defaults: T+17.
- start while busy: ignored, no effect on the sweep or on latched ref_table.
- ref_table changes after the accepted start: no effect on the current sweep.
- start in DONE: immediately restarts; results clear on the accepting edge.
- Reset mid-sweep: returns to IDLE with all outputs cleared; the partial sweep is discarded.
- err_cnt never wraps; its maximum is 2**N_IN, representable in N_IN+1 bits.

Test Plan:
- Golden DUT r = ~a&~b&c | ~a&b&~c | a&~b&~c | a&~b&c, ref_table=8'h36, start pulse at T -> tt_in steps 0..7, two cycles each. At T+17: done=1, busy=0, mismatch_mask=8'h00, err_cnt=0, pass=1.
- Same DUT, ref_table=8'h3E (vector 3, a=0 b=1 c=1, wrongly expected 1) -> mismatch_mask=8'h08, err_cnt=1, pass=0.
- DUT output inverted (r=~golden), ref_table=8'h36 -> mismatch_mask=8'hFF, err_cnt=8, pass=0.
- tt_r forced X at vector 5, otherwise golden -> mismatch_mask=8'h20, err_cnt=1.
- During the golden sweep:
  - start re-pulsed at T+5 -> ignored, done still at T+17.
  - rst=1 at T+8 -> next cycle all outputs 0, state IDLE.
  - fresh start afterwards -> full sweep, pass=1.
- SETTLE=3, golden DUT:
  - each tt_in value held 4 cycles, done at T+33, pass=1.
  - start in DONE -> done=0 and mismatch_mask=0 next cycle, then a new sweep runs.
